countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: MIN_TENS_MAX, default 5, largest legal minutes-tens digit (range 0-9).
REQ-002 clk_1hz  input  1  count clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 load  input  1  synchronous; when 1, latch the preset into the digits and the preset register.
REQ-005 enable  input  1  level; 1 = run, 0 = pause.
REQ-006 set_sec_unit, set_sec_tens, set_min_unit, set_min_tens  input  4 each  BCD preset digits.
REQ-007 sec_unit, sec_tens, min_unit, min_tens  output  4 each  registered BCD count, MM:SS.
REQ-008 running  output  1  registered; 1 only in state RUN.
REQ-009 done  output  1  registered expiry flag.

Function
REQ-010 The block SHALL be an FSM with states IDLE, RUN, PAUSE and EXPIRED.
REQ-011 Preset clamp on load:
- units digits > 9 become 9;
- set_sec_tens > 5 becomes 5;
- set_min_tens > MIN_TENS_MAX becomes MIN_TENS_MAX.
REQ-012 load=1 in any state SHALL:
- copy the clamped preset into the digits and the preset register;
- clear done;
- enter IDLE next cycle;
- take priority over enable.
REQ-013 IDLE:
- enable=1 with count != 00:00 -> RUN (no decrement on that edge);
- enable=1 with count == 00:00 -> stay IDLE.
REQ-014 RUN with enable=1: decrement the count by one second per edge.
REQ-015 RUN with enable=0: -> PAUSE with the count unchanged.
REQ-016 PAUSE:
- hold the count;
- enable=1 -> RUN, with the first decrement on the following edge.
REQ-017 Borrow chain:
- sec_unit 0->9 borrows from sec_tens;
- sec_tens 0->5 borrows from min_unit;
- min_unit 0->9 borrows from min_tens.
REQ-018 The count SHALL never underflow below 00:00, and no digit SHALL ever hold a non-BCD value.
REQ-019 Decrement from 00:01 in RUN:
- the digits become 00:00;
- state becomes EXPIRED;
- done=1 on the same edge.
REQ-020 EXPIRED:
- hold 00:00 and done=1;
- ignore enable;
- exit only via load or reset.
REQ-021 Outputs SHALL change only on a clk_1hz rising edge or asynchronous reset.

Reset
REQ-022 Asserting reset SHALL immediately force:
- all four digits and the preset register to 0;
- state to IDLE;
- running=0 and done=0.
REQ-023 Reset mid-count SHALL discard the count, and the block SHALL not count after release until enable=1.

Configuration
REQ-024 Macro COUNTDOWN_AUTO_RELOAD_EN selects the behaviour of the 00:01 -> zero decrement in RUN (REQ-019).
REQ-025 Defined, on that decrement:
- the digits reload from the preset register;
- state stays RUN;
- done=1 for exactly one cycle;
- a zero preset register instead enters EXPIRED.
REQ-026 Undefined: REQ-019 and REQ-020 apply unchanged, and no preset-reload logic is present.

Verification
REQ-027 Load 01:05, enable=1 -> running=1; after 1 edge 01:05; then 01:04, 01:03, 01:02, 01:01, 01:00, 00:59.
REQ-028 Load 00:03, enable=1 -> after 4 edges count=00:00, done=1, running=0; further enable toggles leave 00:00.
REQ-029 In RUN at 10:20, enable=0 for 3 edges -> holds 10:20 in PAUSE; enable=1 -> 10:20 on 1st edge, 10:19 on 2nd.
REQ-030 Load digits 7,F,C,9 (min_tens..sec_unit) -> count 5,9,5,9 (MM:SS = 59:59).
REQ-031 Assert reset mid-edge-cycle at 03:30 -> outputs 00:00, done=0 without a clock edge.
REQ-032 With COUNTDOWN_AUTO_RELOAD_EN, load 00:02, run -> sequence 00:02, 00:01, 00:02 with a one-cycle done pulse, and running stays 1.

Source files
------------

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer #(
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic       clk_1hz,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] set_sec_unit,
    input  logic [3:0] set_sec_tens,
    input  logic [3:0] set_min_unit,
    input  logic [3:0] set_min_tens,
    output logic [3:0] sec_unit,
    output logic [3:0] sec_tens,
    output logic [3:0] min_unit,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_e;

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        running_q;
    logic        done_q, done_d;
    logic [15:0] preset_c;
    logic [15:0] dec_c;
    logic        is_zero, is_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] pre_q, pre_d;
`endif

    // Count layout: {min_tens, min_unit, sec_tens, sec_unit}
    always_comb begin
        preset_c[15:12] = (set_min_tens > MT_MAX) ? MT_MAX : set_min_tens;
        preset_c[11:8]  = (set_min_unit > 4'd9) ? 4'd9 : set_min_unit;
        preset_c[7:4]   = (set_sec_tens > 4'd5) ? 4'd5 : set_sec_tens;
        preset_c[3:0]   = (set_sec_unit > 4'd9) ? 4'd9 : set_sec_unit;
    end

    always_comb begin
        dec_c = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            dec_c[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            dec_c[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                dec_c[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                dec_c[7:4] = 4'd5;
                if (cnt_q[11:8] != 4'd0) begin
                    dec_c[11:8] = cnt_q[11:8] - 4'd1;
                end else begin
                    dec_c[11:8]  = 4'd9;
                    dec_c[15:12] = cnt_q[15:12] - 4'd1;
                end
            end
        end
    end

    assign is_zero = (cnt_q == 16'h0000);
    assign is_one  = (cnt_q == 16'h0001);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        pre_d   = pre_q;
`endif
        if (load) begin
            cnt_d   = preset_c;
            state_d = IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            pre_d   = preset_c;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && !is_zero) state_d = RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state_d = PAUSE;
                    end else if (is_one || is_zero) begin
                        // Final second: either wrap to the preset or stop at zero
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (pre_q != 16'h0000) begin
                            cnt_d = pre_q;
                        end else begin
                            cnt_d   = 16'h0000;
                            state_d = EXPIRED;
                        end
`else
                        cnt_d   = 16'h0000;
                        state_d = EXPIRED;
`endif
                    end else begin
                        cnt_d = dec_c;
                    end
                end
                PAUSE: begin
                    if (enable) state_d = RUN;
                end
                EXPIRED: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'h0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) pre_q <= 16'h0000;
        else       pre_q <= pre_d;
    end
`endif

    assign min_tens = cnt_q[15:12];
    assign min_unit = cnt_q[11:8];
    assign sec_tens = cnt_q[7:4];
    assign sec_unit = cnt_q[3:0];
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-based reference model plus directed literal checks.
// Define COUNTDOWN_AUTO_RELOAD_EN to exercise the auto-reload build.
module tb_countdown_timer;

    logic       clk_1hz;
    logic       reset;
    logic       load;
    logic       enable;
    logic [3:0] set_sec_unit, set_sec_tens, set_min_unit, set_min_tens;
    logic [3:0] sec_unit, sec_tens, min_unit, min_tens;
    logic       running;
    logic       done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    countdown_timer #(.MIN_TENS_MAX(5)) dut (
        .clk_1hz     (clk_1hz),
        .reset       (reset),
        .load        (load),
        .enable      (enable),
        .set_sec_unit(set_sec_unit),
        .set_sec_tens(set_sec_tens),
        .set_min_unit(set_min_unit),
        .set_min_tens(set_min_tens),
        .sec_unit    (sec_unit),
        .sec_tens    (sec_tens),
        .min_unit    (min_unit),
        .min_tens    (min_tens),
        .running     (running),
        .done        (done)
    );

    initial begin
        clk_1hz = 1'b0;
        forever #5 clk_1hz = ~clk_1hz;
    end

    // Model: count as total seconds; mode 0 idle, 1 run, 2 pause, 3 expired
    typedef struct packed {
        int   secs;
        int   pre;
        int   mode;
        logic dn;
    } mdl_t;

    mdl_t m;

    function automatic int preset_secs(input int mt, input int mu,
                                       input int st, input int su);
        if (mt > 5) mt = 5;
        if (mu > 9) mu = 9;
        if (st > 5) st = 5;
        if (su > 9) su = 9;
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic mdl_t step(input mdl_t c, input logic ld, input logic en,
                                  input int mt, input int mu,
                                  input int st, input int su);
        mdl_t n;
        n = c;
        if (ld) begin
            n.secs = preset_secs(mt, mu, st, su);
            n.pre  = n.secs;
            n.mode = 0;
            n.dn   = 1'b0;
            return n;
        end
        n.dn = (c.mode == 3);
        case (c.mode)
            0: if (en && c.secs > 0) n.mode = 1;
            1: begin
                if (!en) begin
                    n.mode = 2;
                end else if (c.secs <= 1) begin
                    n.dn = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (c.pre > 0) begin
                        n.secs = c.pre;
                    end else begin
                        n.secs = 0;
                        n.mode = 3;
                    end
`else
                    n.secs = 0;
                    n.mode = 3;
`endif
                end else begin
                    n.secs = c.secs - 1;
                end
            end
            2: if (en) n.mode = 1;
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    always @(posedge clk_1hz or posedge reset) begin
        if (reset) m <= '0;
        else m <= step(m, load, enable, int'(set_min_tens), int'(set_min_unit),
                       int'(set_sec_tens), int'(set_sec_unit));
    end

    wire [15:0] dut_cnt = {min_tens, min_unit, sec_tens, sec_unit};

    always @(negedge clk_1hz) begin
        if (chk_en) begin
            checks++;
            if (dut_cnt !== to_bcd(m.secs)) begin
                failures++;
                $display("FAIL count t=%0t got %h want %h", $time, dut_cnt, to_bcd(m.secs));
            end
            checks++;
            if (running !== (m.mode == 1)) begin
                failures++;
                $display("FAIL running t=%0t got %b want %b", $time, running, (m.mode == 1));
            end
            checks++;
            if (done !== m.dn) begin
                failures++;
                $display("FAIL done t=%0t got %b want %b", $time, done, m.dn);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk_1hz);
            #1;
        end
    endtask

    task automatic lit(input string nm, input logic [15:0] c,
                       input logic r, input logic d);
        checks++;
        if (dut_cnt !== c || running !== r || done !== d) begin
            failures++;
            $display("FAIL %s got %h run=%b done=%b want %h run=%b done=%b",
                     nm, dut_cnt, running, done, c, r, d);
        end
    endtask

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mu,
                           input logic [3:0] st, input logic [3:0] su);
        set_min_tens = mt;
        set_min_unit = mu;
        set_sec_tens = st;
        set_sec_unit = su;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    logic [15:0] seq27 [6];

    initial begin
        seq27 = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};
        reset = 1'b1;
        load = 1'b0;
        enable = 1'b0;
        set_min_tens = '0;
        set_min_unit = '0;
        set_sec_tens = '0;
        set_sec_unit = '0;
        tick(2);
        lit("reset_state", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;

        do_load(4'd0, 4'd1, 4'd0, 4'd5);
        lit("load_0105", 16'h0105, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        lit("run_0105", 16'h0105, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            lit("dec_seq", seq27[i], 1'b1, 1'b0);
        end

        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        lit("load_prio", 16'h1234, 1'b0, 1'b0);
        tick();
        lit("idle_to_run", 16'h1234, 1'b1, 1'b0);

        do_load(4'd1, 4'd0, 4'd2, 4'd0);
        tick();
        lit("run_1020", 16'h1020, 1'b1, 1'b0);
        enable = 1'b0;
        tick(3);
        lit("pause_hold", 16'h1020, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        lit("resume_1st", 16'h1020, 1'b1, 1'b0);
        tick();
        lit("resume_2nd", 16'h1019, 1'b1, 1'b0);

        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        tick(2);
        lit("borrow_chain", 16'h0959, 1'b1, 1'b0);

        do_load(4'h7, 4'hF, 4'hC, 4'h9);
        lit("clamp_5959", 16'h5959, 1'b0, 1'b0);
        tick(2);
        lit("dec_5958", 16'h5958, 1'b1, 1'b0);

        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        tick(2);
        lit("idle_zero", 16'h0000, 1'b0, 1'b0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        tick(4);
        lit("expire", 16'h0000, 1'b0, 1'b1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        lit("expired_hold", 16'h0000, 1'b0, 1'b1);
        do_load(4'd0, 4'd0, 4'd1, 4'd0);
        lit("expired_exit", 16'h0010, 1'b0, 1'b0);
        enable = 1'b1;
`else
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        tick();
        lit("ar_0002", 16'h0002, 1'b1, 1'b0);
        tick();
        lit("ar_0001", 16'h0001, 1'b1, 1'b0);
        tick();
        lit("ar_reload", 16'h0002, 1'b1, 1'b1);
        tick();
        lit("ar_pulse_end", 16'h0001, 1'b1, 1'b0);
`endif

        do_load(4'd0, 4'd3, 4'd3, 4'd0);
        tick();
        lit("run_0330", 16'h0330, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        lit("async_reset", 16'h0000, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick(3);
        lit("post_reset_idle", 16'h0000, 1'b0, 1'b0);
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        tick();
        lit("post_reset_run", 16'h0005, 1'b1, 1'b0);

        repeat (300) begin
            set_min_tens = 4'($urandom_range(0, 15));
            set_min_unit = 4'($urandom_range(0, 15));
            set_sec_tens = 4'($urandom_range(0, 15));
            set_sec_unit = 4'($urandom_range(0, 15));
            load   = ($urandom_range(0, 19) == 0);
            enable = ($urandom_range(0, 3) != 0);
            tick();
        end
        load = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
